rrp_online_add: RTL
===================

// Module: rRp_online_add
// PURPOSE
//  Digit-serial, MSD-first online adder/subtractor for radix-RADIX signed-digit operands.
//  Each operand digit is in [-A,A], A=RADIX-1 (maximally redundant).
//  Accepts one digit pair per cycle and emits sum digits MSD-first with online delay 1.
//  A frame is WIDTH input digit pairs; the result is WIDTH+1 digits.
//  Successor to the parallel rRp_add; it feeds the MSDF multiply/accumulate datapath.
// PARAMETERS
//  RADIX  4  digit radix; power of two, >=4 (radix 2 needs delay 2 and is not supported)
//  WIDTH  6  digits per operand frame, >=2
//  D      $clog2(RADIX)+1 (localparam)  bits per digit, two's complement
// PORTS
//  clock      in   1  rising-edge clock
//  reset_n    in   1  asynchronous, active-low reset
//  valid_in   in   1  x_in/y_in/sub_in valid this cycle
//  ready_out  out  1  block accepts a digit pair this cycle (accept = valid_in & ready_out)
//  x_in       in   D  operand X digit, MSD first, range [-A,A]
//  y_in       in   D  operand Y digit, MSD first, range [-A,A]
//  sub_in     in   1  sampled on the first accepted digit only; 1 => compute X-Y for the whole frame
//  valid_out  out  1  s_out holds a result digit
//  s_out      out  D  sum digit, MSD first, range [-A,A]; weight RADIX^(WIDTH-k) for output k
//  first_out  out  1  with valid_out: digit k=0 (weight RADIX^WIDTH)
//  last_out   out  1  with valid_out: digit k=WIDTH (weight 1)
// BEHAVIOUR
//  Reset: all outputs, state, counter and residual are cleared immediately; after reset ready_out=1.
//  Per accepted pair j: p = x_j + (sub ? -y_j : y_j), range [-2A,2A].
//   Transfer and residual: t_j = +1 if p>=A, -1 if p<=-A, else 0; w_j = p - RADIX*t_j, range [-1..A-1] or symmetric.
//   Output digit: s = w_{j-1} + t_j, with w_{-1}=0; result is within [-A,A], so no saturation is needed.
//  All outputs are registered. The edge accepting pair j drives output digit k=j on the next cycle (valid_out=1).
//  FSM:
//   IDLE: ready_out=1. On accept: latch sub, cnt=1, store w_0, emit t_0 with first_out=1, go to RUN.
//   RUN: ready_out=1. On accept: emit w_prev+t_j, store w_j, cnt++. When cnt reaches WIDTH, go to FLUSH.
//   FLUSH: ready_out=0 for exactly one cycle. Emit w_{WIDTH-1} with last_out=1, clear w, go to IDLE.
//  Input gaps: valid_in=0 in RUN holds all state; valid_out=0 that cycle. Gaps of any length are legal.
//  Back-to-back frames: the first digit of the next frame may be accepted on the cycle after FLUSH.
//   Frame-to-frame throughput is WIDTH+1 cycles.
//  Output flow control: none; the consumer must always accept valid_out digits.
//  sub_in is ignored on non-first digits. x_in/y_in outside [-A,A] are undefined and are not checked.
//  Reset mid-frame discards the partial frame. No partial output is produced afterwards.
//  Internal arithmetic uses D+2 bit signed values. s_out is truncated to D bits after the range is proven.
// STRUCTURE
//  Package rRp_pkg:
//   - function digit_bits(radix) = $clog2(radix)+1
//   - localparam A
//   - FSM state enum {IDLE,RUN,FLUSH}
//  Sub-module rRp_digit_tw (combinational): (x,y,sub) -> (t[1:0] signed, w[D-1:0]). Reused by a future multi-lane adder.
//  Top level: FSM, $clog2(WIDTH+1) counter, residual register, output registers.
// TESTING (RADIX=4, WIDTH=6, A=3; value = sum s_k*4^(6-k))
//  1. All x=3, all y=3, add, continuous valid:
//     -> s = 1,3,3,3,3,3,2 (=8190); first_out on k=0, last_out on k=6; ready_out=0 for 1 cycle.
//  2. x = y = 3,-2,1,0,-3,2, sub=1 -> seven digits all 0; valid_out asserted for 7 cycles.
//  3. Boundary pairs (3,0),(-3,0),(2,1),(-2,-1),(0,0),(1,-1):
//     -> t/w = (1,-1),(-1,1),(1,-1),(-1,1),(0,0),(0,0); the value check passes.
//  4. Case 1 with valid_in low for 3 cycles after digit 2:
//     -> same 7 digits; valid_out low during the gap; no extra digits.
//  5. Two frames back-to-back (case 1, then case 2):
//     -> the second frame's first digit is accepted the cycle after FLUSH; 14 digits total, both correct.
//  6. reset_n low after digit 3 of a frame, then a new case 1 frame:
//     -> outputs drop to 0 asynchronously; only the new frame's 7 correct digits follow.
//  Scoreboard: 500 random frames (digits uniform in [-3,3], random sub, random gaps).
//   Check the recomposed value equals x±y and every s_out is in [-3,3].

Source files
------------

// File: rtl/rrp_online_add_pkg.sv
// rtl/rrp_online_add_pkg.sv - shared types and helpers for the MSD-first online adder
package rrp_online_add_pkg;

  function automatic int digit_bits(input int radix);
    return $clog2(radix) + 1;
  endfunction

  localparam int RADIX_DEF = 4;
  localparam int A = RADIX_DEF - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

endpackage

// File: rtl/rrp_online_add_digit_tw.sv
// rtl/rrp_online_add_digit_tw.sv - per-digit transfer/residual split of x +/- y
module rrp_online_add_digit_tw
  import rrp_online_add_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int D     = digit_bits(RADIX)
) (
  input  logic [D-1:0]       x_i,
  input  logic [D-1:0]       y_i,
  input  logic               sub_i,
  output logic signed [1:0]  t_o,
  output logic [D-1:0]       w_o
);

  localparam int PW = D + 2;
  localparam logic signed [PW-1:0] A_S = PW'(RADIX - 1);
  localparam logic [D-1:0]         R_D = D'(RADIX);

  logic signed [PW-1:0] xe, ye, p;

  assign xe = {{2{x_i[D-1]}}, x_i};
  assign ye = {{2{y_i[D-1]}}, y_i};
  assign p  = sub_i ? (xe - ye) : (xe + ye);

  // w always fits D bits, so the low D bits of p adjusted modulo 2^D are exact
  always_comb begin
    t_o = 2'sd0;
    w_o = p[D-1:0];
    if (p >= A_S) begin
      t_o = 2'sd1;
      w_o = p[D-1:0] - R_D;
    end else if (p <= -A_S) begin
      t_o = -2'sd1;
      w_o = p[D-1:0] + R_D;
    end
  end

endmodule

// File: rtl/rrp_online_add.sv
// rtl/rrp_online_add.sv - digit-serial MSD-first signed-digit adder/subtractor, online delay 1
module rrp_online_add
  import rrp_online_add_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int WIDTH = 6,
  localparam int D    = digit_bits(RADIX),
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         valid_in,
  output logic         ready_out,
  input  logic [D-1:0] x_in,
  input  logic [D-1:0] y_in,
  input  logic         sub_in,
  output logic         valid_out,
  output logic [D-1:0] s_out,
  output logic         first_out,
  output logic         last_out
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sub_q, sub_d;
  logic [D-1:0]    w_q, w_d;
  logic            valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic [D-1:0]    s_q, s_d;

  logic            accept, sub_eff;
  logic signed [1:0] t;
  logic [D-1:0]    w, t_ext;

  assign ready_out = (state_q != FLUSH);
  assign accept    = valid_in & ready_out;
  assign sub_eff   = (state_q == IDLE) ? sub_in : sub_q;
  assign t_ext     = {{(D-2){t[1]}}, t};

  rrp_online_add_digit_tw #(.RADIX(RADIX), .D(D)) u_tw (
    .x_i   (x_in),
    .y_i   (y_in),
    .sub_i (sub_eff),
    .t_o   (t),
    .w_o   (w)
  );

  // Output sums stay within [-A,A], so D-bit modular addition is exact
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    w_d     = w_q;
    valid_d = 1'b0;
    s_d     = '0;
    first_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sub_d   = sub_in;
          cnt_d   = CW'(1);
          w_d     = w;
          valid_d = 1'b1;
          s_d     = t_ext;
          first_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          s_d     = w_q + t_ext;
          w_d     = w;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        s_d     = w_q;
        valid_d = 1'b1;
        last_d  = 1'b1;
        w_d     = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      w_q     <= '0;
      valid_q <= 1'b0;
      s_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      s_q     <= s_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign s_out     = s_q;
  assign first_out = first_q;
  assign last_out  = last_q;

endmodule
